// File: rtl/adder8_seq.sv
// Byte-serial multi-precision adder built around a single 8-bit adder stage.
// Optional signed-overflow output is enabled by defining ADDER8_SEQ_OVF_EN.

// 8-bit ripple adder slice with carry in/out.
// Latency: combinational.
// Backpressure: none (pure datapath).
module adder8 (
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);
    logic [8:0] full;

    assign full = {1'b0, x} + {1'b0, y} + {8'd0, cin};
    assign sum  = full[7:0];
    assign cout = full[8];
endmodule

// Sequences one adder8 over NBYTES bytes, LSB first, chaining carry in a register.
// Latency: accept at end of cycle 0, RUN cycles 1..NBYTES, out_valid in cycle NBYTES+1.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
module adder8_seq #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    input  logic                  cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*NBYTES-1:0]   sum,
    output logic                  cout
`ifdef ADDER8_SEQ_OVF_EN
    ,
    output logic                  ovf
`endif
);
    localparam int W  = 8 * NBYTES;
    localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NBYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            carry_q, carry_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [7:0]      add_sum;
    logic            add_cout;
    logic [W-1:0]    sum_shift;

    adder8 u_adder8 (
        .x    (a_q[7:0]),
        .y    (b_q[7:0]),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // New byte enters at the top so that after NBYTES shifts byte 0 sits at the bottom.
    always_comb begin
        sum_shift = sum_q >> 8;
        sum_shift[W-1 -: 8] = add_sum;
    end

`ifdef ADDER8_SEQ_OVF_EN
    logic a_msb_q, a_msb_d;
    logic b_msb_q, b_msb_d;
`endif

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
`ifdef ADDER8_SEQ_OVF_EN
        a_msb_d   = a_msb_q;
        b_msb_d   = b_msb_q;
`endif
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = ST_RUN;
`ifdef ADDER8_SEQ_OVF_EN
                    a_msb_d = a[W-1];
                    b_msb_d = b[W-1];
`endif
                end
            end
            ST_RUN: begin
                sum_d   = sum_shift;
                carry_d = add_cout;
                a_d     = a_q >> 8;
                b_d     = b_q >> 8;
                // Counter parks at the last value rather than wrapping.
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
`ifdef ADDER8_SEQ_OVF_EN
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
`ifdef ADDER8_SEQ_OVF_EN
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
`endif
        end
    end

    assign sum  = sum_q;
    assign cout = (state_q == ST_DONE) && carry_q;

`ifdef ADDER8_SEQ_OVF_EN
    assign ovf = (state_q == ST_DONE) && (a_msb_q == b_msb_q) && (sum_q[W-1] != a_msb_q);
`endif
endmodule

// File: tb/tb_adder8_seq.sv
// Self-checking bench for adder8_seq: directed scenarios plus randomized operands
// compared against an arithmetic reference model.
module tb_adder8_seq;
    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  sum;
    logic          cout;
`ifdef ADDER8_SEQ_OVF_EN
    logic          ovf;
`endif

    int checks = 0;
    int errors = 0;

    adder8_seq #(.NBYTES(NB)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef ADDER8_SEQ_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t required < 500000", $time);
        $fatal(1, "watchdog expired");
    end

    // Reference model: plain wide-integer arithmetic.
    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        longint unsigned t;
        t = longint'(x) + longint'(y) + longint'(c);
        return t[W:0];
    endfunction

`ifdef ADDER8_SEQ_OVF_EN
    function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        longint s;
        longint lim;
        s   = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
        lim = longint'(1) <<< (W - 1);
        return (s > lim - 1) || (s < -lim);
    endfunction
`endif

    task automatic step();
        @(negedge clk);
    endtask

    // Runs one transaction; lat is cycles from accept to out_valid, -1 on timeout.
    task automatic do_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ci,
                         input int hold, output logic [W-1:0] s, output logic co,
                         output logic ov, output int lat);
        int n;
        n = 0;
        out_ready = (hold == 0);
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        a = ai;
        b = bi;
        cin = ci;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        cin = 1'($urandom_range(0, 1));
        lat = 1;
        while (!out_valid && lat < 50) begin
            step();
            lat++;
        end
        if (!out_valid) lat = -1;
        s  = sum;
        co = cout;
`ifdef ADDER8_SEQ_OVF_EN
        ov = ovf;
`else
        ov = 1'b0;
`endif
        repeat (hold) step();
        out_ready = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        a = 32'hDEADBEEF;
        b = 32'h12345678;
        cin = 1'b1;
        repeat (2) step();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++;
        if (sum !== '0) begin errors++; $display("FAIL reset_sum got %h exp 0", sum); end
        checks++;
        if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout got %b exp 0", cout); end
`ifdef ADDER8_SEQ_OVF_EN
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", ovf); end
`endif
        in_valid = 1'b0;
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        logic [W-1:0] s;
        logic co, ov;
        int lat;
        do_op(32'd12, 32'd5, 1'b0, 0, s, co, ov, lat);
        checks++;
        if (lat != NB + 1) begin errors++; $display("FAIL basic_latency got %0d exp %0d", lat, NB + 1); end
        checks++;
        if (s !== 32'd17) begin errors++; $display("FAIL basic_sum got %h exp %h", s, 32'd17); end
        checks++;
        if (co !== 1'b0) begin errors++; $display("FAIL basic_cout got %b exp 0", co); end
    endtask

    task automatic test_ripple();
        logic [W-1:0] va[3];
        logic [W-1:0] vb[3];
        logic         vc[3];
        logic [W-1:0] es[3];
        logic         ec[3];
        logic [W-1:0] s;
        logic co, ov;
        int lat;
        va = '{32'h000000FF, 32'hFFFFFFFF, 32'h80000000};
        vb = '{32'h00000001, 32'h00000000, 32'h80000000};
        vc = '{1'b0, 1'b1, 1'b1};
        es = '{32'h00000100, 32'h00000000, 32'h00000001};
        ec = '{1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            do_op(va[i], vb[i], vc[i], 0, s, co, ov, lat);
            checks++;
            if (s !== es[i] || co !== ec[i]) begin
                errors++;
                $display("FAIL ripple_%0d got sum %h cout %b exp sum %h cout %b", i, s, co, es[i], ec[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] exp_s;
        int n;
        exp_s = 32'h11223344;
        out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 50) begin step(); n++; end
        a = 32'h01020304;
        b = 32'h10203040;
        cin = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin step(); n++; end
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_done_timeout got out_valid %b exp 1", out_valid); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || sum !== exp_s || cout !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold_%0d got valid %b sum %h cout %b in_ready %b exp 1 %h 0 0",
                         i, out_valid, sum, cout, in_ready, exp_s);
            end
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release got in_ready %b out_valid %b exp 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid_run();
        int n;
        bit seen;
        out_ready = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin step(); n++; end
        a = 32'h12345678;
        b = 32'h11111111;
        cin = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state got in_ready %b out_valid %b sum %h cout %b exp 1 0 0 0",
                     in_ready, out_valid, sum, cout);
        end
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL midrst_stale got out_valid pulse 1 exp 0"); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] res[$];
        int acc_cyc[2];
        int acc_n;
        int cyc;
        res.delete();
        acc_cyc = '{0, 0};
        acc_n = 0;
        cyc = 0;
        out_ready = 1'b1;
        a = 32'd1;
        b = 32'd1;
        cin = 1'b0;
        in_valid = 1'b1;
        while (cyc < 60 && res.size() < 2) begin
            if (out_valid) res.push_back(sum);
            if (in_valid && in_ready && acc_n < 2) begin
                acc_cyc[acc_n] = cyc;
                acc_n++;
            end
            step();
            cyc++;
            if (acc_n == 1) begin
                a = 32'h12345678;
                b = 32'h11111111;
            end
            if (acc_n == 2) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        checks++;
        if (res.size() != 2 || acc_n != 2) begin
            errors++;
            $display("FAIL b2b_count got results %0d accepts %0d exp 2 2", res.size(), acc_n);
        end else begin
            checks++;
            if (res[0] !== 32'd2) begin errors++; $display("FAIL b2b_first got %h exp %h", res[0], 32'd2); end
            checks++;
            if (res[1] !== 32'h23456789) begin errors++; $display("FAIL b2b_second got %h exp 23456789", res[1]); end
            checks++;
            if (acc_cyc[1] - acc_cyc[0] != NB + 2) begin
                errors++;
                $display("FAIL b2b_spacing got %0d exp %0d", acc_cyc[1] - acc_cyc[0], NB + 2);
            end
        end
        step();
    endtask

`ifdef ADDER8_SEQ_OVF_EN
    task automatic test_ovf();
        logic [W-1:0] s;
        logic co, ov;
        int lat;
        do_op(32'h7FFFFFFF, 32'd1, 1'b0, 0, s, co, ov, lat);
        checks++;
        if (ov !== 1'b1 || co !== 1'b0) begin
            errors++;
            $display("FAIL ovf_pos got ovf %b cout %b exp 1 0", ov, co);
        end
        do_op(32'hFFFFFFFF, 32'd1, 1'b0, 0, s, co, ov, lat);
        checks++;
        if (ov !== 1'b0 || co !== 1'b1) begin
            errors++;
            $display("FAIL ovf_wrap got ovf %b cout %b exp 0 1", ov, co);
        end
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_idle got %b exp 0", ovf); end
    endtask
`endif

    task automatic test_random();
        logic [W-1:0] ra, rb, s, exp_s;
        logic rc, co, ov;
        logic [W:0] full;
        int lat;
        for (int i = 0; i < 25; i++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(0, 1));
            if (i % 5 == 0) rb = ~ra;
            full = ref_add(ra, rb, rc);
            exp_s = full[W-1:0];
            do_op(ra, rb, rc, $urandom_range(0, 3), s, co, ov, lat);
            checks++;
            if (lat != NB + 1 || s !== exp_s || co !== full[W]) begin
                errors++;
                $display("FAIL rand_%0d a %h b %h cin %b got sum %h cout %b lat %0d exp sum %h cout %b lat %0d",
                         i, ra, rb, rc, s, co, lat, exp_s, full[W], NB + 1);
            end
`ifdef ADDER8_SEQ_OVF_EN
            checks++;
            if (ov !== ref_ovf(ra, rb, rc)) begin
                errors++;
                $display("FAIL rand_ovf_%0d a %h b %h cin %b got %b exp %b", i, ra, rb, rc, ov, ref_ovf(ra, rb, rc));
            end
`endif
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        cin = 1'b0;
        test_reset();
        test_basic();
        test_ripple();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
`ifdef ADDER8_SEQ_OVF_EN
        test_ovf();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
